multicycle_add_sub: RTL and testbench

- Parametrised, sequential successor of the fixed-width ripple-carry adder: adds or subtracts two WIDTH-bit operands CHUNK bits per clock.
- A registered carry links the chunks.
- Supplies the processor ALU with a small-area add/sub path that supports carry chaining, signed overflow and backpressure.
- valid/ready handshake on both the operand side and the result side.

---
 rtl/multicycle_add_sub_pkg.sv | 24 ++
 rtl/multicycle_add_sub_adder_chunk.sv | 40 ++++
 rtl/multicycle_add_sub.sv | 124 ++++++++++++
 tb/tb_multicycle_add_sub.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/multicycle_add_sub_pkg.sv
// Shared types and sizing helpers for the chunk-serial add/sub unit.
package multicycle_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 4;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_NUM_CHUNKS = num_chunks(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/multicycle_add_sub_adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the top can derive signed overflow from the final chunk.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);
  logic [CHUNK:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (s_o[i]),
      .c_o (c[i+1])
    );
  end

  assign c_o     = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];
endmodule

// File: rtl/multicycle_add_sub.sv
// Chunk-serial adder/subtractor: WIDTH-bit add or A-B, CHUNK bits per clock,
// with a registered carry between chunks and valid/ready on both sides.
module multicycle_add_sub
  import multicycle_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  localparam int unsigned NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int unsigned IW         = idx_width(NUM_CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             chunk_cm;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (op_a_q[CHUNK-1:0]),
    .b_i     (op_b_q[CHUNK-1:0]),
    .c_i     (carry_q),
    .s_o     (chunk_s),
    .c_o     (chunk_c),
    .c_msb_o (chunk_cm)
  );

  // Operands shift right and the sum fills from the top, so chunk k is always
  // at bit 0 of the operands; after NUM_CHUNKS steps sum_q is fully aligned.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? ~c_in : c_in;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        op_a_d  = op_a_q >> CHUNK;
        op_b_d  = op_b_q >> CHUNK;
        sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
        carry_d = chunk_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          c_out_d = chunk_c;
          ovf_d   = chunk_c ^ chunk_cm;
          zero_d  = (sum_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Directed bench for multicycle_add_sub: a 32/4 instance and a 32/32 instance.
module tb_multicycle_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit / 4-bit-chunk instance
  logic        iv, ir, sb, ci, ov, ordy, co, ovf, z;
  logic [31:0] a, b, s;
  // 32-bit / 32-bit-chunk instance
  logic        iv2, ir2, sb2, ci2, ov2, ordy2, co2, ovf2, z2;
  logic [31:0] a2, b2, s2;

  int checks   = 0;
  int failures = 0;
  int cyc;
  bit seen;

  multicycle_add_sub #(.WIDTH(32), .CHUNK(4)) dut (
    .clock(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .sub(sb), .c_in(ci), .out_valid(ov), .out_ready(ordy), .sum(s),
    .c_out(co), .overflow(ovf), .zero(z)
  );

  multicycle_add_sub #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clock(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .sub(sb2), .c_in(ci2), .out_valid(ov2), .out_ready(ordy2), .sum(s2),
    .c_out(co2), .overflow(ovf2), .zero(z2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with out_valid high or budget spent.
  task automatic run_op(input bit big, input logic [31:0] ta, input logic [31:0] tb_,
                        input bit ts, input bit tc, output int cycles);
    if (big) begin iv2 = 1'b1; a2 = ta; b2 = tb_; sb2 = ts; ci2 = tc; end
    else     begin iv  = 1'b1; a  = ta; b  = tb_; sb  = ts; ci  = tc; end
    @(posedge clk); #1;
    iv = 1'b0; iv2 = 1'b0;
    cycles = 0;
    while (!(big ? ov2 : ov) && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic pop(input bit big);
    if (big) ordy2 = 1'b1; else ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0; ordy2 = 1'b0;
  endtask

  initial begin
    {iv, sb, ci, ordy, iv2, sb2, ci2, ordy2} = '0;
    a = '0; b = '0; a2 = '0; b2 = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 32'(ir), 32'd1);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_sum", s, 32'd0);
    check("rst_flags", {29'd0, co, ovf, z}, 32'd0);
    check("rst_in_ready32", 32'(ir2), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: signed overflow on add, latency 8
    run_op(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, cyc);
    check("t1_latency", 32'(cyc), 32'd8);
    check("t1_sum", s, 32'h8000_0000);
    check("t1_flags", {29'd0, co, ovf, z}, 32'b010);
    pop(1'b0);
    check("t1_back_idle", 32'(ir), 32'd1);

    // 2: 5 - 7 borrows
    run_op(1'b0, 32'd5, 32'd7, 1'b1, 1'b0, cyc);
    check("t2_latency", 32'(cyc), 32'd8);
    check("t2_sum", s, 32'hFFFF_FFFE);
    check("t2_flags", {29'd0, co, ovf, z}, 32'b000);
    pop(1'b0);

    // 3: all-ones plus carry-in wraps to zero
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, cyc);
    check("t3_sum", s, 32'h0);
    check("t3_flags", {29'd0, co, ovf, z}, 32'b101);
    pop(1'b0);

    // 4: backpressure holds result; inputs ignored while DONE
    run_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, cyc);
    check("t4_sum", s, 32'h2345_6789);
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; a = 32'(i * 32'h0101_0101); b = ~a; sb = i[0]; ci = 1'b1;
      @(posedge clk); #1;
      check("t4_hold_sum", s, 32'h2345_6789);
      check("t4_hold_state", {29'd0, ir, ov, co}, 32'b010);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("t4_idle_after_ready", {30'd0, ir, ov}, 32'b10);
    iv = 1'b0;
    @(posedge clk); #1;
    check("t4_no_accept_on_exit", {30'd0, ir, ov}, 32'b10);

    // 5: reset during the third BUSY cycle aborts the op
    iv = 1'b1; a = 32'h0000_FFFF; b = 32'h1; sb = 1'b0; ci = 1'b0;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_abort_state", {30'd0, ir, ov}, 32'b10);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov) seen = 1'b1;
    end
    check("t5_no_stale_valid", 32'(seen), 32'd0);
    run_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, cyc);
    check("t5_latency", 32'(cyc), 32'd8);
    check("t5_sum", s, 32'd7);
    pop(1'b0);

    // 6: single-chunk instance, most-negative minus one
    run_op(1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b0, cyc);
    check("t6_latency", 32'(cyc), 32'd1);
    check("t6_sum", s2, 32'h7FFF_FFFF);
    check("t6_flags", {29'd0, co2, ovf2, z2}, 32'b110);
    pop(1'b1);
    check("t6_back_idle", 32'(ir2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
